// File: rtl/apb_pkg.sv
// Shared widths, bus types and FSM encoding for the APB requester.
package apb_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic  write;
        addr_t addr;
        data_t wdata;
        strb_t strb;
    } apb_cmd_t;

    // Reads never present write data or strobes on the bus.
    function automatic apb_cmd_t bus_view(apb_cmd_t cmd);
        apb_cmd_t v;
        v = cmd;
        if (!cmd.write) begin
            v.wdata = '0;
            v.strb  = '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/apb_if.sv
// APB bus bundle between one requester and one completer.
interface apb_if;
    import apb_pkg::*;

    logic  PSEL;
    logic  PENABLE;
    logic  PWRITE;
    addr_t PADDR;
    data_t PWDATA;
    strb_t PSTRB;
    logic  PREADY;
    logic  PSLVERR;
    data_t PRDATA;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PREADY, PSLVERR, PRDATA
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PREADY, PSLVERR, PRDATA
    );

endinterface

// File: rtl/apb_master.sv
// APB requester: one command in, one SETUP/ACCESS transfer out, one response back,
// with an ACCESS wait-state limit that aborts a transfer whose completer never answers.
module apb_master
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       PCLK,
    input  logic       PRESET,
    // Command port: a command transfers on a cycle where cmd_valid and cmd_ready are
    // both 1; the producer holds cmd_* stable while cmd_valid=1 and cmd_ready=0.
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  addr_t      cmd_addr,
    input  data_t      cmd_wdata,
    input  strb_t      cmd_strb,
    output logic       rsp_valid,
    output data_t      rsp_rdata,
    output logic       rsp_slverr,
    output logic       rsp_timeout,
    apb_if.master      apb,
    output apb_state_t state
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    apb_state_t      next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic            in_access;
    logic            complete;
    logic            timeout_hit;
    logic            accept;
    apb_cmd_t        bus_cmd;

    assign in_access   = (state == ACCESS);
    assign complete    = in_access && apb.PREADY;
    assign timeout_hit = in_access && (wait_cnt == CNT_LAST) && !apb.PREADY;
    assign cmd_ready   = !PRESET && ((state == IDLE) || (complete && !timeout_hit));
    assign accept      = cmd_valid && cmd_ready;
    assign bus_cmd     = bus_view('{write: cmd_write, addr: cmd_addr,
                                    wdata: cmd_wdata, strb: cmd_strb});

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? SETUP : IDLE;
            SETUP:   next_state = ACCESS;
            ACCESS: begin
                if (complete)         next_state = accept ? SETUP : IDLE;
                else if (timeout_hit) next_state = IDLE;
                else                  next_state = ACCESS;
            end
            default: next_state = IDLE;
        endcase
    end

    // PSEL/PENABLE follow the state being entered so they are registered yet exact.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= IDLE;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
            apb.PSTRB   <= '0;
        end else begin
            state       <= next_state;
            apb.PSEL    <= (next_state != IDLE);
            apb.PENABLE <= (next_state == ACCESS);
            if (accept) begin
                apb.PWRITE <= bus_cmd.write;
                apb.PADDR  <= bus_cmd.addr;
                apb.PWDATA <= bus_cmd.wdata;
                apb.PSTRB  <= bus_cmd.strb;
            end
        end
    end

    // Held at zero outside ACCESS, so it starts from zero on every entry.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt <= '0;
        end else if (!in_access) begin
            wait_cnt <= '0;
        end else if (!apb.PREADY) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid   <= complete || timeout_hit;
            rsp_rdata   <= (complete && !apb.PWRITE) ? apb.PRDATA : '0;
            rsp_slverr  <= complete ? apb.PSLVERR : timeout_hit;
            rsp_timeout <= timeout_hit;
        end
    end

endmodule
